clk_rst_seq: RTL and testbench
==============================

// Module: clk_rst_seq
// PURPOSE
//  Clock/reset sequencer for the MCU on the iCE40 build. Runs on the PLL output clk_16M.
//  Derives the core clock clk_o and the memory read clock clk_x2_o from a free-running divider.
//  Holds the core in reset until PLL lock is stable, then releases reset after a fixed number of core cycles.
//  Adds glitch-free halt and single-step of the core clock for board debug.
// PARAMETERS
//  DIV_LOG2    14  clk_o = cnt[DIV_LOG2-1], clk_x2_o = cnt[DIV_LOG2-2]; core period = 2**DIV_LOG2 clk_16M cycles (>=2)
//  LOCK_FILT   16  consecutive clk_16M cycles pll_lock_i must be high before the divider starts
//  RST_CYCLES   3  full core periods the divider runs with rst_n_o low before reset is released
// PORTS
//  clk_16M     in   1  PLL output clock, sole clock of this block
//  rst_nn      in   1  asynchronous, active-low reset
//  pll_lock_i  in   1  PLL LOCK, asynchronous; synchronised internally
//  halt_i      in   1  freeze request for the core clock, asynchronous level
//  step_i      in   1  single-step request, asynchronous; rising edge is the event
//  clk_o       out  1  core clock, registered bit of cnt
//  clk_x2_o    out  1  memory read clock (2x clk_o), registered bit of cnt
//  rst_n_o     out  1  core/peripheral reset, active-low, registered
//  state_o     out  2  FSM state: 0 LOCK, 1 RST, 2 RUN, 3 HALT
// BEHAVIOUR
//  - Reset (rst_nn=0): cnt=0, clk_o=0, clk_x2_o=0, rst_n_o=0, state LOCK, filter/step counters 0.
//  - pll_lock_i, halt_i, step_i pass through 2-FF synchronisers; step edge = sync & ~sync_d (1 cycle).
//  - cnt (DIV_LOG2 bits) increments by 1 per clk_16M while the divider runs and wraps to 0.
//    cnt==0 is the park point: both clocks low, clk_o has just fallen.
//  - LOCK: cnt held 0, rst_n_o=0. lock_cnt counts cycles with synced lock=1 and clears on any 0.
//    When lock_cnt reaches LOCK_FILT-1 -> RST.
//  - RST: divider runs, rst_n_o=0. rst_cnt increments on each wrap to 0.
//    After RST_CYCLES wraps -> RUN, and rst_n_o=1 on that same edge (at the clk_o fall, half a period of setup).
//  - RUN: divider runs, rst_n_o=1. If synced halt=1 when the next cnt value is 0 -> HALT, cnt parks at 0.
//    A halt request never truncates a clk_o or clk_x2_o pulse.
//  - HALT: cnt held 0, rst_n_o stays 1. Synced halt=0 -> RUN, divider resumes from 0 (clk_o rises 2**(DIV_LOG2-1) cycles later).
//    Step edge -> stepping; divider runs exactly one full period back to 0, then HALT (state_o stays 3).
//    If halt drops during a step: the step completes, then -> RUN with no park cycle.
//  - Step edges outside HALT, or during an active step, are ignored (not queued).
//  - halt asserted during LOCK/RST takes no effect until RUN; it is then honoured at the first wrap.
//  - Synced lock=0 in RST/RUN/HALT: next edge -> LOCK, cnt=0, rst_n_o=0, counters cleared.
//    A truncated clk_o pulse is permitted only because rst_n_o falls on the same edge.
//  - Simultaneous lock loss and halt/step: lock loss wins.
// STRUCTURE
//  - Package mcu_clk_pkg: state encodings ST_LOCK/ST_RST/ST_RUN/ST_HALT (2 bits) and the state_t typedef.
//  - Sub-module sync_2ff: async-reset 2-flop synchroniser, instanced three times.
//  - Remaining logic (divider, FSM, filter and reset counters, step tracking) is flat in this module.
// TESTING (DIV_LOG2=3, LOCK_FILT=4, RST_CYCLES=3; times are clk_16M edges)
//  1. rst_nn 0->1, pll_lock_i=1 at t0 -> all outputs 0 during reset.
//     Divider starts at t0+2(sync)+4; rst_n_o rises 24 cycles later, coincident with clk_o falling.
//  2. pll_lock_i pulses low 2 cycles after 3 stable cycles in LOCK -> filter restarts; start delayed by a full LOCK_FILT.
//  3. pll_lock_i=0 in RUN at cnt=5 -> rst_n_o=0, clk_o=0, state_o=0 after sync delay; lock restored -> full test-1 sequence repeats.
//  4. halt_i=1 in RUN at cnt=1 -> clocks finish the current period, park at cnt=0; state_o=3, rst_n_o stays 1.
//  5. HALT, step_i pulse -> exactly one clk_o high pulse (4 cycles) and two clk_x2_o pulses; back to park.
//     A second step_i during the step is ignored.
//  6. HALT, halt_i=0 -> state_o=2; first clk_o rise 4 cycles after resume; period 8, duty 50%.

Source files
------------

// File: rtl/mcu_clk_pkg.sv
// ---------------------------------------------------------------------------
// mcu_clk_pkg
//   Shared definitions for the MCU clock/reset sequencer.
//   The state encoding is also the value driven on clk_rst_seq.state_o.
//   Encodings: ST_LOCK waits for a stable PLL lock, ST_RST runs the divider
//   with the core held in reset, ST_RUN is normal operation, and ST_HALT
//   is the debug freeze. Single-step happens inside ST_HALT.
// ---------------------------------------------------------------------------
package mcu_clk_pkg;

    typedef enum logic [1:0] {
        ST_LOCK = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous level. It has an
//   asynchronous active-low reset that clears both flops.
//   Ports:
//     clk    in  destination clock
//     rst_n  in  asynchronous active-low reset
//     d_i    in  asynchronous input level
//     q_o    out synchronised level, two clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
//   Clock/reset sequencer for the MCU. Everything runs on clk_16M.
//   A free-running counter provides two derived clocks. The core clock
//   clk_o is the counter MSB. The memory read clock clk_x2_o is the bit
//   below the MSB, so it runs at twice the core rate.
//   Sequencing:
//     1. Wait for a filtered PLL lock.
//     2. Run the divider with the core held in reset for RST_CYCLES
//        core periods.
//     3. Release the reset.
//   Halt and single-step always park at cnt==0, so the derived clocks are
//   never cut short.
//   Ports:
//     clk_16M     in  PLL output clock
//     rst_nn      in  asynchronous active-low reset
//     pll_lock_i  in  PLL lock, asynchronous
//     halt_i      in  halt request level, asynchronous
//     step_i      in  single-step request, asynchronous; the rising edge
//                     is the event
//     clk_o       out core clock (cnt MSB)
//     clk_x2_o    out memory read clock (cnt MSB-1)
//     rst_n_o     out core reset, active-low, registered
//     state_o     out sequencer state (0 LOCK, 1 RST, 2 RUN, 3 HALT)
// ---------------------------------------------------------------------------
module clk_rst_seq
    import mcu_clk_pkg::*;
#(
    parameter int DIV_LOG2   = 14,
    parameter int LOCK_FILT  = 16,
    parameter int RST_CYCLES = 3
) (
    input  logic       clk_16M,
    input  logic       rst_nn,
    input  logic       pll_lock_i,
    input  logic       halt_i,
    input  logic       step_i,
    output logic       clk_o,
    output logic       clk_x2_o,
    output logic       rst_n_o,
    output logic [1:0] state_o
);

    localparam int LOCK_W = $clog2(LOCK_FILT + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam logic [DIV_LOG2-1:0] CNT_TOP   = '1;
    localparam logic [LOCK_W-1:0]   LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
    localparam logic [RST_W-1:0]    RST_LAST  = RST_W'(RST_CYCLES - 1);

    logic lock_s;
    logic halt_s;
    logic step_s;

    sync_2ff u_sync_lock (.clk(clk_16M), .rst_n(rst_nn), .d_i(pll_lock_i), .q_o(lock_s));
    sync_2ff u_sync_halt (.clk(clk_16M), .rst_n(rst_nn), .d_i(halt_i),     .q_o(halt_s));
    sync_2ff u_sync_step (.clk(clk_16M), .rst_n(rst_nn), .d_i(step_i),     .q_o(step_s));

    state_t               state_q,    state_d;
    logic [DIV_LOG2-1:0]  cnt_q,      cnt_d;
    logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [RST_W-1:0]     rst_cnt_q,  rst_cnt_d;
    logic                 rst_n_q,    rst_n_d;
    logic                 stepping_q, stepping_d;
    logic                 step_dly_q, step_dly_d;

    logic [DIV_LOG2-1:0]  cnt_inc;
    logic                 cnt_wrap;
    logic                 step_edge;

    // The counter wraps when it is at all-ones. The next edge then lands on
    // the park point, where clk_o falls.
    assign cnt_inc   = cnt_q + DIV_LOG2'(1);
    assign cnt_wrap  = (cnt_q == CNT_TOP);
    assign step_edge = step_s & ~step_dly_q;

    // Next-state logic. Lock loss is checked first so that it overrides
    // every other request. Parking happens only when the next count is 0,
    // so halting never shortens a clock pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        rst_n_d    = rst_n_q;
        stepping_d = stepping_q;
        step_dly_d = step_s;

        if (!lock_s && (state_q != ST_LOCK)) begin
            state_d    = ST_LOCK;
            cnt_d      = '0;
            lock_cnt_d = '0;
            rst_cnt_d  = '0;
            rst_n_d    = 1'b0;
            stepping_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOCK: begin
                    cnt_d   = '0;
                    rst_n_d = 1'b0;
                    if (!lock_s) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        lock_cnt_d = '0;
                        state_d    = ST_RST;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end
                ST_RST: begin
                    cnt_d = cnt_inc;
                    if (cnt_wrap) begin
                        if (rst_cnt_q == RST_LAST) begin
                            rst_cnt_d = '0;
                            rst_n_d   = 1'b1;
                            state_d   = ST_RUN;
                        end else begin
                            rst_cnt_d = rst_cnt_q + RST_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_inc;
                    if (cnt_wrap && halt_s) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (stepping_q) begin
                        // A step always completes its period. If the halt
                        // request drops meanwhile, the sequencer goes straight
                        // back to running without a park cycle.
                        cnt_d = cnt_inc;
                        if (cnt_wrap) begin
                            stepping_d = 1'b0;
                            if (!halt_s) begin
                                state_d = ST_RUN;
                            end
                        end
                    end else begin
                        cnt_d = '0;
                        if (!halt_s) begin
                            state_d = ST_RUN;
                        end else if (step_edge) begin
                            stepping_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                    rst_n_d = 1'b0;
                end
            endcase
        end
    end

    // State registers. Reset clears everything, so the core starts in reset
    // with both clocks low.
    always_ff @(posedge clk_16M or negedge rst_nn) begin
        if (!rst_nn) begin
            state_q    <= ST_LOCK;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            rst_cnt_q  <= '0;
            rst_n_q    <= 1'b0;
            stepping_q <= 1'b0;
            step_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            rst_n_q    <= rst_n_d;
            stepping_q <= stepping_d;
            step_dly_q <= step_dly_d;
        end
    end

    assign clk_o    = cnt_q[DIV_LOG2-1];
    assign clk_x2_o = cnt_q[DIV_LOG2-2];
    assign rst_n_o  = rst_n_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_rst_seq
//   Scoreboard bench for clk_rst_seq with DIV_LOG2=3, LOCK_FILT=4 and
//   RST_CYCLES=3.
//   The stimulus process drives inputs on the falling edge and advances a
//   behavioural model by one clk_16M cycle. It then queues the outputs the
//   model expects after the next rising edge. A separate monitor pops one
//   entry per rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_clk_rst_seq;

    localparam int DIV_LOG2   = 3;
    localparam int LOCK_FILT  = 4;
    localparam int RST_CYCLES = 3;
    localparam int PERIOD     = 1 << DIV_LOG2;
    localparam int M_LOCK = 0, M_RST = 1, M_RUN = 2, M_HALT = 3;

    logic       clk_16M = 1'b0;
    logic       rst_nn;
    logic       pll_lock_i;
    logic       halt_i;
    logic       step_i;
    logic       clk_o;
    logic       clk_x2_o;
    logic       rst_n_o;
    logic [1:0] state_o;

    clk_rst_seq #(
        .DIV_LOG2  (DIV_LOG2),
        .LOCK_FILT (LOCK_FILT),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_16M   (clk_16M),
        .rst_nn    (rst_nn),
        .pll_lock_i(pll_lock_i),
        .halt_i    (halt_i),
        .step_i    (step_i),
        .clk_o     (clk_o),
        .clk_x2_o  (clk_x2_o),
        .rst_n_o   (rst_n_o),
        .state_o   (state_o)
    );

    always #5 clk_16M = ~clk_16M;

    typedef struct packed {
        logic       clk;
        logic       clk2;
        logic       rstn;
        logic [1:0] state;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   monCycle    = 0;

    // The behavioural model tracks the divider position within a core period
    // and counts filter observations and reset wraps. The sync pipelines
    // model the two-flop input latency.
    int mMode, mPos, mLockRun, mWraps;
    bit mStepping, mRstn;
    bit lkH[2];
    bit hlH[2];
    bit stH[3];

    task automatic modelReset();
        mMode = M_LOCK; mPos = 0; mLockRun = 0; mWraps = 0;
        mStepping = 0; mRstn = 0;
        lkH[0] = 0; lkH[1] = 0; hlH[0] = 0; hlH[1] = 0;
        stH[0] = 0; stH[1] = 0; stH[2] = 0;
    endtask

    task automatic modelEdge(input bit lock, input bit halt, input bit step);
        bit lockS, haltS, stepEvt;
        int nextPos;
        lockS   = lkH[1];
        haltS   = hlH[1];
        stepEvt = stH[1] && !stH[2];
        lkH[1] = lkH[0]; lkH[0] = lock;
        hlH[1] = hlH[0]; hlH[0] = halt;
        stH[2] = stH[1]; stH[1] = stH[0]; stH[0] = step;
        nextPos = (mPos + 1) % PERIOD;
        if (!lockS && mMode != M_LOCK) begin
            mMode = M_LOCK; mPos = 0; mRstn = 0;
            mLockRun = 0; mWraps = 0; mStepping = 0;
        end else if (mMode == M_LOCK) begin
            if (lockS) begin
                mLockRun++;
                if (mLockRun == LOCK_FILT) begin
                    mLockRun = 0;
                    mMode = M_RST;
                end
            end else begin
                mLockRun = 0;
            end
        end else if (mMode == M_RST) begin
            mPos = nextPos;
            if (mPos == 0) begin
                mWraps++;
                if (mWraps == RST_CYCLES) begin
                    mWraps = 0; mRstn = 1; mMode = M_RUN;
                end
            end
        end else if (mMode == M_RUN) begin
            mPos = nextPos;
            if (mPos == 0 && haltS) mMode = M_HALT;
        end else begin
            if (mStepping) begin
                mPos = nextPos;
                if (mPos == 0) begin
                    mStepping = 0;
                    if (!haltS) mMode = M_RUN;
                end
            end else if (!haltS) begin
                mMode = M_RUN;
            end else if (stepEvt) begin
                mStepping = 1;
            end
        end
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.clk   = (mPos >= PERIOD / 2);
        e.clk2  = ((mPos % (PERIOD / 2)) >= PERIOD / 4);
        e.rstn  = mRstn;
        e.state = mMode[1:0];
        return e;
    endfunction

    task automatic applyStimulus(input bit rst, input bit lock, input bit halt, input bit step, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_16M);
            rst_nn     = rst;
            pll_lock_i = lock;
            halt_i     = halt;
            step_i     = step;
            if (!rst) modelReset();
            else      modelEdge(lock, halt, step);
            expQ.push_back(modelOut());
        end
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t got;
        got = {clk_o, clk_x2_o, rst_n_o, state_o};
        assertCount++;
        if (got !== e) begin
            failCount++;
            $display("[TB] FAIL outputs @cycle %0d: got clk=%b x2=%b rstn=%b state=%0d, expected clk=%b x2=%b rstn=%b state=%0d",
                     monCycle, got.clk, got.clk2, got.rstn, got.state, e.clk, e.clk2, e.rstn, e.state);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        assertCount++;
        if (got != want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Scoreboard monitor: one expected entry per rising edge.
    always begin
        @(posedge clk_16M);
        #1;
        monCycle++;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Independent timing check: reset must release exactly RST_CYCLES core
    // periods after the divider starts, and on a falling clk_o.
    int   rstEntry = -1;
    logic [1:0] prevState = 2'd0;
    logic prevRstn = 1'b0;
    always begin
        @(posedge clk_16M);
        #1;
        if (state_o == 2'd0) rstEntry = -1;
        else if (state_o == 2'd1 && prevState == 2'd0) rstEntry = monCycle;
        if (rst_n_o === 1'b1 && prevRstn === 1'b0) begin
            assertCount++;
            if (rstEntry < 0 || (monCycle - rstEntry) != RST_CYCLES * PERIOD || clk_o !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset release timing: got %0d cycles clk_o=%b, expected %0d cycles clk_o=0",
                         monCycle - rstEntry, clk_o, RST_CYCLES * PERIOD);
            end
        end
        prevState = state_o;
        prevRstn  = rst_n_o;
    end

    // Single step from HALT, with a second request while the step is active.
    // Exactly one clk_o pulse and two clk_x2_o pulses are expected.
    task automatic stepWindow();
        int highs = 0;
        int rises = 0;
        bit prevX2 = 0;
        bit st;
        checkValue("halted before step", int'(state_o), M_HALT);
        for (int i = 0; i < 20; i++) begin
            st = (i < 2) || (i == 5) || (i == 6);
            applyStimulus(1, 1, 1, st, 1);
            highs += int'(clk_o);
            if (clk_x2_o && !prevX2) rises++;
            prevX2 = clk_x2_o;
        end
        checkValue("step clk_o high cycles", highs, PERIOD / 2);
        checkValue("step clk_x2_o pulses", rises, 2);
        checkValue("state after step", int'(state_o), M_HALT);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit lock, halt, step;
        int lockLowLeft;
        rst_nn = 1'b0; pll_lock_i = 1'b0; halt_i = 1'b0; step_i = 1'b0;
        modelReset();

        // Power-on, lock stable, full start-up sequence
        applyStimulus(0, 1, 0, 0, 5);
        applyStimulus(1, 1, 0, 0, 40);
        checkValue("running after start-up", int'(state_o), M_RUN);

        // Lock glitch while filtering restarts the filter
        applyStimulus(0, 0, 0, 0, 3);
        applyStimulus(1, 1, 0, 0, 5);
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 45);

        // Lock loss while running, then recovery
        applyStimulus(1, 0, 0, 0, 4);
        applyStimulus(1, 1, 0, 0, 45);

        // Halt, single step, resume
        applyStimulus(1, 1, 1, 0, 14);
        stepWindow();
        applyStimulus(1, 1, 0, 0, 20);
        checkValue("running after resume", int'(state_o), M_RUN);

        // Halt held through LOCK/RST, honoured at first RUN wrap
        applyStimulus(1, 0, 1, 0, 3);
        applyStimulus(1, 1, 1, 0, 50);

        // Halt dropped during a step
        applyStimulus(1, 1, 1, 1, 2);
        applyStimulus(1, 1, 1, 0, 4);
        applyStimulus(1, 1, 0, 0, 20);

        // Randomised traffic with occasional lock drops and one async reset
        lock = 1; halt = 0; step = 0; lockLowLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) lockLowLeft = $urandom_range(1, 6);
            lock = (lockLowLeft == 0);
            if (lockLowLeft > 0) lockLowLeft--;
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            if ($urandom_range(0, 5) == 0) step = ~step;
            applyStimulus((i < 2000 || i > 2002), lock, halt, step, 1);
        end

        repeat (3) @(posedge clk_16M);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
